// File: rtl/alu_ctrl_stage.sv
// ALU control stage between decode and execute: decodes the ALU class and instruction
// fields into ALU/branch/memory/MDU controls, held in a one-entry valid/ready register.
module alu_ctrl_stage #(
    parameter int ALU_OP_W = 4,
    parameter bit M_EXT    = 1'b1,
    parameter int MDU_LAT  = 4,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          alu_ctrl_op,
    input  logic [4:0]          instr_f,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                br_valid,
    output logic [2:0]          br_fn,
    output logic                mem_valid,
    output logic                mem_we,
    output logic [2:0]          mem_fn,
    output logic                mdu_valid,
    output logic [2:0]          mdu_fn
);

    localparam logic [2:0] CLS_B    = 3'd1;
    localparam logic [2:0] CLS_I    = 3'd2;
    localparam logic [2:0] CLS_J    = 3'd3;
    localparam logic [2:0] CLS_JALR = 3'd4;
    localparam logic [2:0] CLS_R    = 3'd5;
    localparam logic [2:0] CLS_S    = 3'd6;
    localparam logic [2:0] CLS_LOAD = 3'd7;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);

    typedef enum logic [1:0] {S_EMPTY, S_BUSY, S_FULL} state_t;

    typedef struct packed {
        logic [3:0] alu;
        logic       br_valid;
        logic [2:0] br_fn;
        logic       mem_valid;
        logic       mem_we;
        logic [2:0] mem_fn;
        logic       mdu_valid;
        logic [2:0] mdu_fn;
    } dec_t;

    state_t           state, state_n;
    dec_t             dec, res;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             b30, b25;
    logic [2:0]       f3;

    assign b30 = instr_f[4];
    assign b25 = instr_f[3];
    assign f3  = instr_f[2:0];

    always_comb begin
        // NOTE: every field gets a default before the case, so no path leaves a latch.
        dec = '0;
        case (alu_ctrl_op)
            CLS_B: begin
                dec.alu      = 4'b1000;
                dec.br_valid = 1'b1;
                dec.br_fn    = f3;
            end
            CLS_I:           dec.alu = (b30 && f3 == 3'b101) ? 4'b1101 : {1'b0, f3};
            CLS_J, CLS_JALR: begin
                dec.br_valid = 1'b1;
                dec.br_fn    = 3'b010;
            end
            CLS_R: begin
                if (M_EXT && b25) begin
                    dec.mdu_valid = 1'b1;
                    dec.mdu_fn    = f3;
                end else begin
                    dec.alu = {b30, f3};
                end
            end
            CLS_S, CLS_LOAD: begin
                dec.mem_valid = 1'b1;
                dec.mem_we    = (alu_ctrl_op == CLS_S);
                dec.mem_fn    = f3;
            end
            default: ;
        endcase
    end

    // Flush discards a same-cycle input even when in_ready is high.
    assign accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) state <= S_EMPTY;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_EMPTY: if (in_valid) state_n = dec.mdu_valid ? S_BUSY : S_FULL;
            S_BUSY:  if (cnt == '0) state_n = S_FULL;
            S_FULL:  if (out_ready) state_n = in_valid ? (dec.mdu_valid ? S_BUSY : S_FULL) : S_EMPTY;
            default: state_n = S_EMPTY;
        endcase
        if (flush) state_n = S_EMPTY;
    end

    always_comb begin
        in_ready  = (state == S_EMPTY) || (state == S_FULL && out_ready);
        out_valid = (state == S_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the result register is reset as well so no stale fields survive a reset.
        if (!rst_n) begin
            res <= '0;
            cnt <= '0;
        end else begin
            if (flush)                            cnt <= '0;
            else if (accept)                      cnt <= dec.mdu_valid ? CNT_LOAD : '0;
            else if (state == S_BUSY && cnt != '0) cnt <= cnt - 1'b1;
            if (accept) res <= dec;
        end
    end

    always_comb begin
        alu_op      = '0;
        alu_op[3:0] = res.alu;
    end

    assign br_valid  = res.br_valid;
    assign br_fn     = res.br_fn;
    assign mem_valid = res.mem_valid;
    assign mem_we    = res.mem_we;
    assign mem_fn    = res.mem_fn;
    assign mdu_valid = res.mdu_valid;
    assign mdu_fn    = res.mdu_fn;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Self-checking bench for alu_ctrl_stage: timestamped transaction model compared every
// cycle, plus directed vectors with hand-computed expectations.
module tb_alu_ctrl_stage;

    localparam int MDU_LAT = 4;

    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [2:0] alu_ctrl_op = '0;
    logic [4:0] instr_f = '0;
    logic in_ready, out_valid, br_valid, mem_valid, mem_we, mdu_valid;
    logic [3:0] alu_op;
    logic [2:0] br_fn, mem_fn, mdu_fn;

    logic in_valid_b = 1'b0, out_ready_b = 1'b1;
    logic [2:0] alu_ctrl_op_b = '0;
    logic [4:0] instr_f_b = '0;
    logic in_ready_b, out_valid_b, br_valid_b, mem_valid_b, mem_we_b, mdu_valid_b;
    logic [3:0] alu_op_b;
    logic [2:0] br_fn_b, mem_fn_b, mdu_fn_b;

    alu_ctrl_stage #(.ALU_OP_W(4), .M_EXT(1'b1), .MDU_LAT(MDU_LAT), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl_op(alu_ctrl_op), .instr_f(instr_f), .out_valid(out_valid),
        .out_ready(out_ready), .alu_op(alu_op), .br_valid(br_valid), .br_fn(br_fn),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_fn(mem_fn), .mdu_valid(mdu_valid),
        .mdu_fn(mdu_fn)
    );

    alu_ctrl_stage #(.ALU_OP_W(4), .M_EXT(1'b0), .MDU_LAT(MDU_LAT), .CNT_W(8)) u_dut_nm (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .alu_ctrl_op(alu_ctrl_op_b), .instr_f(instr_f_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .alu_op(alu_op_b), .br_valid(br_valid_b), .br_fn(br_fn_b),
        .mem_valid(mem_valid_b), .mem_we(mem_we_b), .mem_fn(mem_fn_b),
        .mdu_valid(mdu_valid_b), .mdu_fn(mdu_fn_b)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [3:0] alu;
        logic       br_v;
        logic [2:0] br_fn;
        logic       mem_v;
        logic       we;
        logic [2:0] mem_fn;
        logic       mdu_v;
        logic [2:0] mdu_fn;
    } exp_t;

    function automatic exp_t model_decode(input logic [2:0] cls, input logic [4:0] f);
        exp_t e = '0;
        case (cls)
            3'd1: begin e.alu = 4'd8; e.br_v = 1'b1; e.br_fn = f[2:0]; end
            3'd2: e.alu = (f[4] && f[2:0] == 3'd5) ? 4'd13 : {1'b0, f[2:0]};
            3'd3, 3'd4: begin e.br_v = 1'b1; e.br_fn = 3'd2; end
            3'd5: if (f[3]) begin e.mdu_v = 1'b1; e.mdu_fn = f[2:0]; end
                  else e.alu = {f[4], f[2:0]};
            3'd6, 3'd7: begin e.mem_v = 1'b1; e.we = (cls == 3'd6); e.mem_fn = f[2:0]; end
            default: ;
        endcase
        return e;
    endfunction

    // Model: at most one pending entry, visible from cycle m_t onwards.
    logic m_v;
    exp_t m_f;
    int   m_t, cyc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_v <= 1'b0; m_f <= '0; m_t <= 0; cyc <= 0;
        end else begin
            automatic bit   done = m_v && cyc >= m_t && out_ready;
            automatic bit   rdy  = !m_v || done;
            automatic exp_t e    = model_decode(alu_ctrl_op, instr_f);
            cyc <= cyc + 1;
            if (flush) m_v <= 1'b0;
            else if (in_valid && rdy) begin
                m_v <= 1'b1;
                m_f <= e;
                m_t <= cyc + 1 + (e.mdu_v ? MDU_LAT : 0);
            end else if (done) m_v <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            automatic bit ev = m_v && cyc >= m_t;
            check("model out_valid", out_valid, ev);
            check("model in_ready", in_ready, !m_v || (ev && out_ready));
            if (ev) begin
                check("model alu_op", alu_op, m_f.alu);
                check("model br_valid", br_valid, m_f.br_v);
                check("model br_fn", br_fn, m_f.br_fn);
                check("model mem_valid", mem_valid, m_f.mem_v);
                check("model mem_we", mem_we, m_f.we);
                check("model mem_fn", mem_fn, m_f.mem_fn);
                check("model mdu_valid", mdu_valid, m_f.mdu_v);
                check("model mdu_fn", mdu_fn, m_f.mdu_fn);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [2:0] cls;
        logic [4:0] f;
        logic [3:0] alu;
        logic       br_v;
        logic [2:0] br_fn;
        logic       mem_v;
        logic       we;
        logic [2:0] mem_fn;
    } vec_t;

    vec_t sweep[7];

    initial begin
        sweep[0] = '{3'd5, 5'b10000, 4'b1000, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0};
        sweep[1] = '{3'd2, 5'b10101, 4'b1101, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0};
        sweep[2] = '{3'd2, 5'b10000, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0};
        sweep[3] = '{3'd1, 5'b00101, 4'b1000, 1'b1, 3'b101, 1'b0, 1'b0, 3'd0};
        sweep[4] = '{3'd7, 5'b00010, 4'b0000, 1'b0, 3'd0, 1'b1, 1'b0, 3'b010};
        sweep[5] = '{3'd6, 5'b00001, 4'b0000, 1'b0, 3'd0, 1'b1, 1'b1, 3'b001};
        sweep[6] = '{3'd4, 5'b00000, 4'b0000, 1'b1, 3'b010, 1'b0, 1'b0, 3'd0};

        repeat (3) step();
        rst_n = 1'b1;
        @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset in_ready", in_ready, 1);
        check("reset alu_op", alu_op, 0);
        check("reset br/mem/mdu", {br_valid, mem_valid, mdu_valid}, 0);
        step();

        // Decode sweep with out_ready held high.
        for (int i = 0; i < 7; i++) begin
            alu_ctrl_op = sweep[i].cls; instr_f = sweep[i].f; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            @(negedge clk);
            check("sweep out_valid", out_valid, 1);
            check("sweep alu_op", alu_op, sweep[i].alu);
            check("sweep br", {br_valid, br_fn}, {sweep[i].br_v, sweep[i].br_fn});
            check("sweep mem", {mem_valid, mem_we, mem_fn}, {sweep[i].mem_v, sweep[i].we, sweep[i].mem_fn});
            check("sweep mdu_valid", mdu_valid, 0);
            step();
        end

        // Back-to-back: eight I-arith ops, alu_op equals funct3.
        for (int i = 0; i < 8; i++) begin
            alu_ctrl_op = 3'd2; instr_f = {2'b00, 3'(i)}; in_valid = 1'b1;
            @(negedge clk);
            check("b2b in_ready", in_ready, 1);
            if (i > 0) begin
                check("b2b out_valid", out_valid, 1);
                check("b2b alu_op", alu_op, 4'(i - 1));
            end
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b last out_valid", out_valid, 1);
        check("b2b last alu_op", alu_op, 4'd7);
        step();

        // Backpressure for three cycles while FULL.
        alu_ctrl_op = 3'd2; instr_f = 5'b00011; in_valid = 1'b1; out_ready = 1'b0;
        step();
        instr_f = 5'b00110;
        repeat (3) begin
            @(negedge clk);
            check("bp out_valid", out_valid, 1);
            check("bp in_ready", in_ready, 0);
            check("bp alu_op held", alu_op, 4'b0011);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp release in_ready", in_ready, 1);
        check("bp release alu_op", alu_op, 4'b0011);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp next out_valid", out_valid, 1);
        check("bp next alu_op", alu_op, 4'b0110);
        step();

        // M op: four busy cycles, result on the fifth.
        alu_ctrl_op = 3'd5; instr_f = 5'b01100; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 1; c <= MDU_LAT; c++) begin
            @(negedge clk);
            check("mdu busy in_ready", in_ready, 0);
            check("mdu busy out_valid", out_valid, 0);
            step();
        end
        @(negedge clk);
        check("mdu out_valid", out_valid, 1);
        check("mdu mdu_valid", mdu_valid, 1);
        check("mdu mdu_fn", mdu_fn, 3'b100);
        check("mdu alu_op", alu_op, 4'b0000);
        step();

        // Flush during BUSY with a simultaneous input.
        alu_ctrl_op = 3'd5; instr_f = 5'b01000; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        flush = 1'b1; in_valid = 1'b1; alu_ctrl_op = 3'd2; instr_f = 5'b00111;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush out_valid", out_valid, 0);
        check("flush in_ready", in_ready, 1);
        repeat (8) begin
            step();
            @(negedge clk);
            check("flush no stale", out_valid, 0);
        end

        // Flush while FULL and stalled.
        alu_ctrl_op = 3'd2; instr_f = 5'b00001; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("flush full out_valid", out_valid, 0);

        // Asynchronous reset mid-BUSY.
        step();
        alu_ctrl_op = 3'd5; instr_f = 5'b01001; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        check("rst busy out_valid", out_valid, 0);
        check("rst busy in_ready", in_ready, 1);
        check("rst busy fields", {alu_op, mdu_valid, mdu_fn}, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst release in_ready", in_ready, 1);
        check("rst release out_valid", out_valid, 0);

        // Asynchronous reset mid-FULL.
        step();
        alu_ctrl_op = 3'd2; instr_f = 5'b00101; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst full out_valid", out_valid, 0);
        check("rst full alu_op", alu_op, 0);
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        step();

        // M_EXT=0 instance: the same R input is a plain R-type op.
        alu_ctrl_op_b = 3'd5; instr_f_b = 5'b01100; in_valid_b = 1'b1;
        @(negedge clk);
        check("nm in_ready", in_ready_b, 1);
        step();
        in_valid_b = 1'b0;
        @(negedge clk);
        check("nm out_valid", out_valid_b, 1);
        check("nm alu_op", alu_op_b, 4'b0100);
        check("nm mdu_valid", mdu_valid_b, 0);
        step();
        @(negedge clk);
        check("nm drained", out_valid_b, 0);

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
